// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
interface data_memory_sized_if;
    logic        req;
    logic        memwrite;
    logic [1:0]  size;
    logic        unsigned_load;
    logic [31:0] endereco;
    logic [31:0] writedata;
    logic        ready;
    logic        done;
    logic [31:0] readdata;
    logic        misaligned;

    modport master (
        output req, memwrite, size, unsigned_load, endereco, writedata,
        input  ready, done, readdata, misaligned
    );

    modport slave (
        input  req, memwrite, size, unsigned_load, endereco, writedata,
        output ready, done, readdata, misaligned
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with sign/zero-extended loads, alignment checking and a
// req/ready/done handshake with a fixed number of wait states before each access.
module data_memory_sized #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_sized_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AW2    = ADDR_W + 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lat_write, lat_uns;
    logic [1:0]         lat_size;
    logic [AW2-1:0]     lat_addr;
    logic [31:0]        lat_wdata;
    logic               ready_q, done_q, mis_q;
    logic [31:0]        readdata_q;

    logic               accept, access, chk_err;
    logic               in_idle, acc_write, acc_uns;
    logic [1:0]         acc_size, lane;
    logic [AW2-1:0]     acc_addr;
    logic [ADDR_W-1:0]  acc_idx;
    logic [31:0]        acc_wdata, rdword, load_val, store_val;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               unused_c;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array size alias onto the same words.
    assign unused_c = ^bus.endereco[31:AW2];

    // In IDLE a zero-wait access uses the live inputs; later accesses use the latched copy.
    assign in_idle   = (state_q == S_IDLE);
    assign acc_write = in_idle ? bus.memwrite               : lat_write;
    assign acc_size  = in_idle ? bus.size                   : lat_size;
    assign acc_uns   = in_idle ? bus.unsigned_load          : lat_uns;
    assign acc_addr  = in_idle ? bus.endereco[AW2-1:0]      : lat_addr;
    assign acc_wdata = in_idle ? bus.writedata              : lat_wdata;
    assign acc_idx   = acc_addr[AW2-1:2];
    assign lane      = acc_addr[1:0];

    always_comb begin
        chk_err = 1'b0;
        case (bus.size)
            2'b01:   chk_err = bus.endereco[0];
            2'b10:   chk_err = |bus.endereco[1:0];
            2'b11:   chk_err = 1'b1;
            default: chk_err = 1'b0;
        endcase
    end

    // Lane extraction and read-modify-write merge on the addressed word.
    always_comb begin
        rdword   = mem[acc_idx];
        byte_sel = rdword[{lane, 3'b000} +: 8];
        half_sel = acc_addr[1] ? rdword[31:16] : rdword[15:0];
        load_val = rdword;
        store_val = rdword;
        case (acc_size)
            2'b00: begin
                load_val = {{24{byte_sel[7] & ~acc_uns}}, byte_sel};
                store_val[{lane, 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                load_val = {{16{half_sel[15] & ~acc_uns}}, half_sel};
                if (acc_addr[1]) store_val[31:16] = acc_wdata[15:0];
                else             store_val[15:0]  = acc_wdata[15:0];
            end
            default: store_val = acc_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (chk_err) begin
                        state_d = S_DONE;
                    end else if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lat_write  <= 1'b0;
            lat_uns    <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (accept) begin
                lat_write <= bus.memwrite;
                lat_uns   <= bus.unsigned_load;
                lat_size  <= bus.size;
                lat_addr  <= bus.endereco[AW2-1:0];
                lat_wdata <= bus.writedata;
                mis_q     <= chk_err;
                if (chk_err) readdata_q <= '0;
            end
            if (access && !acc_write) readdata_q <= load_val;
        end
    end

    // Array is not reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (access && acc_write && !reset) mem[acc_idx] <= store_val;
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.readdata   = readdata_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: zero-wait vector table plus wait-state and
// reset-abort sequences on instances with 2 and 3 wait states.
module tb_data_memory_sized;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic [2:0]  req_v;
    logic        memwrite, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    data_memory_sized_if bus0 ();
    data_memory_sized_if bus2 ();
    data_memory_sized_if bus3 ();

    assign bus0.req = req_v[0];  assign bus0.memwrite = memwrite;  assign bus0.size = size;
    assign bus0.unsigned_load = uns;  assign bus0.endereco = addr;  assign bus0.writedata = wdata;
    assign bus2.req = req_v[1];  assign bus2.memwrite = memwrite;  assign bus2.size = size;
    assign bus2.unsigned_load = uns;  assign bus2.endereco = addr;  assign bus2.writedata = wdata;
    assign bus3.req = req_v[2];  assign bus3.memwrite = memwrite;  assign bus3.size = size;
    assign bus3.unsigned_load = uns;  assign bus3.endereco = addr;  assign bus3.writedata = wdata;

    data_memory_sized #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst),  .bus(bus0.slave));
    data_memory_sized #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(rst),  .bus(bus2.slave));
    data_memory_sized #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3.slave));

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t tab [23];

    // {ready, done, misaligned, readdata}
    function automatic logic [34:0] obs(input int k);
        case (k)
            0:       obs = {bus0.ready, bus0.done, bus0.misaligned, bus0.readdata};
            1:       obs = {bus2.ready, bus2.done, bus2.misaligned, bus2.readdata};
            default: obs = {bus3.ready, bus3.done, bus3.misaligned, bus3.readdata};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_access(input int k, input int ws, input logic we, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_mis, input string name);
        logic [34:0] o;
        int          n;
        memwrite = we; size = sz; uns = u; addr = a; wdata = wd;
        req_v[k] = 1'b1;
        o = obs(k);
        check({name, " ready before accept"}, 32'(o[34]), 32'd1);
        @(posedge clk); #1;
        req_v[k] = 1'b0;
        // scramble inputs: the latched copy must be used
        memwrite = ~we; size = 2'b00; addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A; uns = ~u;
        n = 0;
        o = obs(k);
        while (!o[33] && n < 20) begin
            @(posedge clk); #1;
            n++;
            o = obs(k);
        end
        check({name, " latency"}, 32'(n), exp_mis ? 32'd0 : 32'(ws));
        check({name, " readdata"}, o[31:0], exp_rd);
        check({name, " misaligned"}, 32'(o[32]), 32'(exp_mis));
        @(posedge clk); #1;
        o = obs(k);
        check({name, " done single pulse"}, 32'(o[33]), 32'd0);
        check({name, " ready after done"}, 32'(o[34]), 32'd1);
    endtask

    initial begin
        logic [34:0] o;
        rst = 1'b1; rst3 = 1'b1; req_v = 3'b000;
        memwrite = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;

        tab[0]  = '{1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tab[1]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        tab[2]  = '{1'b1, 2'b10, 1'b0, 32'h004, 32'h0,        32'hDEADBEEF, 1'b0};
        tab[3]  = '{1'b1, 2'b00, 1'b0, 32'h005, 32'h00000080, 32'hDEADBEEF, 1'b0};
        tab[4]  = '{1'b0, 2'b00, 1'b0, 32'h005, 32'h0,        32'hFFFFFF80, 1'b0};
        tab[5]  = '{1'b0, 2'b00, 1'b1, 32'h005, 32'h0,        32'h00000080, 1'b0};
        tab[6]  = '{1'b0, 2'b10, 1'b0, 32'h004, 32'h0,        32'h00008000, 1'b0};
        tab[7]  = '{1'b1, 2'b10, 1'b0, 32'h000, 32'h0BADF00D, 32'h00008000, 1'b0};
        tab[8]  = '{1'b1, 2'b01, 1'b0, 32'h003, 32'h00001234, 32'h00000000, 1'b1};
        tab[9]  = '{1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h0BADF00D, 1'b0};
        tab[10] = '{1'b0, 2'b11, 1'b0, 32'h000, 32'h0,        32'h00000000, 1'b1};
        tab[11] = '{1'b0, 2'b10, 1'b0, 32'h002, 32'h0,        32'h00000000, 1'b1};
        tab[12] = '{1'b1, 2'b10, 1'b0, 32'h400, 32'h11223344, 32'h00000000, 1'b0};
        tab[13] = '{1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h11223344, 1'b0};
        tab[14] = '{1'b0, 2'b01, 1'b0, 32'h402, 32'h0,        32'h00001122, 1'b0};
        tab[15] = '{1'b0, 2'b01, 1'b0, 32'h400, 32'h0,        32'h00003344, 1'b0};
        tab[16] = '{1'b1, 2'b00, 1'b0, 32'h403, 32'h000000F0, 32'h00003344, 1'b0};
        tab[17] = '{1'b0, 2'b01, 1'b0, 32'h002, 32'h0,        32'hFFFFF022, 1'b0};
        tab[18] = '{1'b0, 2'b01, 1'b1, 32'h002, 32'h0,        32'h0000F022, 1'b0};
        tab[19] = '{1'b0, 2'b00, 1'b1, 32'h001, 32'h0,        32'h00000033, 1'b0};
        tab[20] = '{1'b1, 2'b01, 1'b0, 32'h006, 32'h0000ABCD, 32'h00000033, 1'b0};
        tab[21] = '{1'b0, 2'b10, 1'b0, 32'h004, 32'h0,        32'hABCD8000, 1'b0};
        tab[22] = '{1'b0, 2'b01, 1'b0, 32'h001, 32'h0,        32'h00000000, 1'b1};

        #12;
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            check($sformatf("reset[%0d] ready", k),      32'(o[34]), 32'd1);
            check($sformatf("reset[%0d] done", k),       32'(o[33]), 32'd0);
            check($sformatf("reset[%0d] misaligned", k), 32'(o[32]), 32'd0);
            check($sformatf("reset[%0d] readdata", k),   o[31:0],    32'd0);
        end

        for (int i = 0; i < 23; i++)
            do_access(0, 0, tab[i].we, tab[i].sz, tab[i].u, tab[i].a, tab[i].wd,
                      tab[i].exp_rd, tab[i].exp_mis, $sformatf("w0 v%0d", i));

        // Two wait states: exact ready/done timeline, req held high, address changed after accept
        do_access(1, 2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE0001, 32'h0, 1'b0, "w2 store");
        do_access(1, 2, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "w2 misaligned");
        memwrite = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
        req_v[1] = 1'b1;
        @(posedge clk); #1;
        addr = 32'h20;
        for (int c = 1; c <= 4; c++) begin
            o = obs(1);
            check($sformatf("w2 cycle%0d ready", c), 32'(o[34]), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("w2 cycle%0d done", c),  32'(o[33]), (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) check("w2 held-req readdata", o[31:0], 32'hCAFE0001);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        req_v[1] = 1'b0;
        @(posedge clk); #1;
        o = obs(1);
        check("w2 no second done", 32'(o[33]), 32'd0);

        // Three wait states: reset during WAIT drops the pending store
        do_access(2, 3, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, "w3 store");
        do_access(2, 3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, "w3 load");
        memwrite = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hAAAA5555;
        req_v[2] = 1'b1;
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        o = obs(2);
        check("w3 busy in wait", 32'(o[34]), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        o = obs(2);
        check("w3 abort ready", 32'(o[34]), 32'd1);
        check("w3 abort readdata", o[31:0], 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            o = obs(2);
            check($sformatf("w3 no done %0d", c), 32'(o[33]), 32'd0);
            @(posedge clk); #1;
        end
        do_access(2, 3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, "w3 store discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
